// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - state encoding and sizing helper shared by the serial subtractor slice
package serial_sub_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_RUN  = RUN,
        S_DONE = DONE
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - combinational one-bit full subtractor cell
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first; SERIAL_SUB_OVF_EN adds the ovf port
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             bout,
    output logic             ovf
`else
    output logic             bout
`endif
);

    localparam int CW = clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FINISH   = CW'(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             br;
    logic             d;
    logic             br_nxt;

    full_subtractor u_cell (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (br),
        .d    (d),
        .bout (br_nxt)
    );

    // The borrow FF doubles as the borrow-out result once all bits are consumed.
    assign bout = br;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            sa    <= '0;
            sb    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // One extra RUN cycle after the last shift publishes the result.
                    if (cnt == FINISH) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        diff <= {d, diff[WIDTH-1:1]};
                        sa   <= sa >> 1;
                        sb   <= sb >> 1;
                        br   <= br_nxt;
                        cnt  <= cnt + CW'(1);
`ifdef SERIAL_SUB_OVF_EN
                        if (cnt == LAST_BIT) begin
                            ovf <= br ^ br_nxt;
                        end
`endif
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int checks;
    int failures;
    int cyc;
    int pulses;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
        .bout  (bout),
        .ovf   (ovf)
`else
        .bout  (bout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected)
        else begin
            failures = failures + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Issue a start at the next rising edge; returns at the falling edge after acceptance.
    task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bv_in);
        a     = av;
        b     = bv;
        bin   = bv_in;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n = n + 1;
        end
    endtask

    task automatic count_done(input int span, output int n);
        n = 0;
        for (int i = 0; i < span; i++) begin
            @(negedge clk);
            if (done === 1'b1) n = n + 1;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        bin      = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_diff", diff, 0);
        check("reset_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset_ovf", ovf, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // 5 - 3 with latency check
        start_op(8'h05, 8'h03, 1'b0);
        check("t1_busy_after_accept", busy, 1);
        wait_done(cyc);
        check("t1_latency", cyc, WIDTH + 1);
        check("t1_diff", diff, 8'h02);
        check("t1_bout", bout, 0);
        check("t1_busy_at_done", busy, 0);
        @(negedge clk);
        check("t1_done_one_cycle", done, 0);
        check("t1_diff_held", diff, 8'h02);

        start_op(8'h00, 8'h01, 1'b0);
        wait_done(cyc);
        check("t2a_diff", diff, 8'hFF);
        check("t2a_bout", bout, 1);

        start_op(8'hFF, 8'hFF, 1'b1);
        wait_done(cyc);
        check("t2b_diff", diff, 8'hFF);
        check("t2b_bout", bout, 1);

        start_op(8'h5A, 8'h5A, 1'b0);
        wait_done(cyc);
        check("equal_diff", diff, 8'h00);
        check("equal_bout", bout, 0);

        start_op(8'h00, 8'h00, 1'b1);
        wait_done(cyc);
        check("zero_minus_bin_diff", diff, 8'hFF);
        check("zero_minus_bin_bout", bout, 1);

        start_op(8'h10, 8'h20, 1'b0);
        wait_done(cyc);
        check("wrap_diff", diff, 8'hF0);
        check("wrap_bout", bout, 1);

`ifdef SERIAL_SUB_OVF_EN
        start_op(8'h80, 8'h01, 1'b0);
        wait_done(cyc);
        check("t3a_diff", diff, 8'h7F);
        check("t3a_ovf", ovf, 1);
        start_op(8'h10, 8'h01, 1'b0);
        wait_done(cyc);
        check("t3b_diff", diff, 8'h0F);
        check("t3b_ovf", ovf, 0);
`endif

        // start while busy must be ignored
        start_op(8'h09, 8'h04, 1'b0);
        @(negedge clk);
        @(negedge clk);
        start_op(8'hAA, 8'h00, 1'b0);
        wait_done(cyc);
        check("t4_latency_rest", cyc, WIDTH + 1 - 3);
        check("t4_diff", diff, 8'h05);
        count_done(2 * WIDTH, pulses);
        check("t4_no_extra_done", pulses, 0);

        // reset mid-operation aborts without done
        start_op(8'h37, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_busy", busy, 0);
        check("t5_diff", diff, 0);
        check("t5_done", done, 0);
        rst_n = 1'b1;
        count_done(2 * WIDTH, pulses);
        check("t5_no_done", pulses, 0);
        start_op(8'h20, 8'h01, 1'b0);
        wait_done(cyc);
        check("t5_fresh_diff", diff, 8'h1F);

        // back-to-back start in the DONE cycle
        start_op(8'h09, 8'h04, 1'b0);
        wait_done(cyc);
        check("t6_first_done", done, 1);
        check("t6_first_diff", diff, 8'h05);
        start_op(8'h30, 8'h10, 1'b0);
        check("t6_busy_after_b2b", busy, 1);
        check("t6_done_cleared", done, 0);
        wait_done(cyc);
        check("t6_second_latency", cyc, WIDTH + 1);
        check("t6_second_diff", diff, 8'h20);
        check("t6_second_bout", bout, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
